// File: rtl/comparator_pkg.sv
// Shared types and constants for the switch-to-LED magnitude comparator.
// The result bundle bit order matches the LED index constants.
package comparator_pkg;

  localparam int LED_GT = 0;
  localparam int LED_EQ = 1;
  localparam int LED_LT = 2;

  typedef struct packed {
    logic lt;
    logic eq;
    logic gt;
  } cmp_result_t;

endpackage

// File: rtl/sync_ff.sv
// Depth x width flop chain with asynchronous active-low clear.
// Used to bring asynchronous switch inputs into the clock domain.
module sync_ff #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stg [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        stg[i] <= '0;
      end
    end else begin
      stg[0] <= d;
      for (int i = 1; i < DEPTH; i++) begin
        stg[i] <= stg[i-1];
      end
    end
  end

  assign q = stg[DEPTH-1];

endmodule

// File: rtl/comparator.sv
// Magnitude comparator: synchronised operands A and B drive
// three registered one-hot status LEDs (gt, eq, lt).
module comparator
  import comparator_pkg::*;
#(
  parameter int WIDTH       = 1,
  parameter int SIGNED      = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             led1,
  output logic             led2,
  output logic             led3
);

  logic [WIDTH-1:0] a_s;
  logic [WIDTH-1:0] b_s;
  cmp_result_t      res;
  cmp_result_t      res_q;
  logic             primed;

  function automatic cmp_result_t compare(
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b
  );
    cmp_result_t r;
    r.eq = (a == b);
    if (SIGNED != 0) begin
      r.gt = $signed(a) > $signed(b);
      r.lt = $signed(a) < $signed(b);
    end else begin
      r.gt = a > b;
      r.lt = a < b;
    end
    return r;
  endfunction

  sync_ff #(
    .DEPTH(SYNC_STAGES),
    .WIDTH(WIDTH)
  ) u_sync_a (
    .clk  (sys_clk),
    .rst_n(sys_rst_n),
    .d    (A),
    .q    (a_s)
  );

  sync_ff #(
    .DEPTH(SYNC_STAGES),
    .WIDTH(WIDTH)
  ) u_sync_b (
    .clk  (sys_clk),
    .rst_n(sys_rst_n),
    .d    (B),
    .q    (b_s)
  );

  assign res = compare(a_s, b_s);

  // primed marks that the LED register has been loaded since reset
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      res_q  <= '0;
      primed <= 1'b0;
    end else begin
      res_q  <= res;
      primed <= 1'b1;
    end
  end

  assign led1 = res_q[LED_GT];
  assign led2 = res_q[LED_EQ];
  assign led3 = res_q[LED_LT];

  always_comb begin
    if (sys_rst_n && primed) begin
      assert ($onehot({led1, led2, led3}));
    end
  end

endmodule

// File: tb/tb_comparator.sv
// Directed and swept checks of the comparator LED outputs
// across several width/signedness configurations.
module tb_comparator;

  logic clk = 1'b0;
  logic clk_en = 1'b1;
  logic rst_n = 1'b0;

  logic       a1, b1;
  logic [3:0] a4, b4;
  logic       as1, bs1;
  logic [7:0] a8, b8;

  logic l1_1, l1_2, l1_3;
  logic l4u_1, l4u_2, l4u_3;
  logic l4s_1, l4s_2, l4s_3;
  logic l1s_1, l1s_2, l1s_3;
  logic l8u_1, l8u_2, l8u_3;
  logic l8s_1, l8s_2, l8s_3;

  int checks = 0;
  int failures = 0;

  always #10 if (clk_en) clk = ~clk;

  comparator dut (
    .sys_clk(clk), .sys_rst_n(rst_n), .A(a1), .B(b1),
    .led1(l1_1), .led2(l1_2), .led3(l1_3)
  );

  comparator #(.WIDTH(4), .SIGNED(0)) u4u (
    .sys_clk(clk), .sys_rst_n(rst_n), .A(a4), .B(b4),
    .led1(l4u_1), .led2(l4u_2), .led3(l4u_3)
  );

  comparator #(.WIDTH(4), .SIGNED(1)) u4s (
    .sys_clk(clk), .sys_rst_n(rst_n), .A(a4), .B(b4),
    .led1(l4s_1), .led2(l4s_2), .led3(l4s_3)
  );

  comparator #(.WIDTH(1), .SIGNED(1)) u1s (
    .sys_clk(clk), .sys_rst_n(rst_n), .A(as1), .B(bs1),
    .led1(l1s_1), .led2(l1s_2), .led3(l1s_3)
  );

  comparator #(.WIDTH(8), .SIGNED(0)) u8u (
    .sys_clk(clk), .sys_rst_n(rst_n), .A(a8), .B(b8),
    .led1(l8u_1), .led2(l8u_2), .led3(l8u_3)
  );

  comparator #(.WIDTH(8), .SIGNED(1), .SYNC_STAGES(3)) u8s (
    .sys_clk(clk), .sys_rst_n(rst_n), .A(a8), .B(b8),
    .led1(l8s_1), .led2(l8s_2), .led3(l8s_3)
  );

  task automatic check(input string tag, input logic [2:0] got,
                       input logic [2:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // Golden compare: signed order equals unsigned order with MSB flipped.
  function automatic logic [2:0] gold(input logic [7:0] a,
                                      input logic [7:0] b,
                                      input bit s);
    logic [7:0] x, y;
    x = s ? (a ^ 8'h80) : a;
    y = s ? (b ^ 8'h80) : b;
    return {x > y, x == y, x < y};
  endfunction

  task automatic edge_chk(input string tag, input logic [2:0] exp);
    @(posedge clk); #1;
    check(tag, {l1_1, l1_2, l1_3}, exp);
  endtask

  logic [1:0] vec [4];
  logic [2:0] vexp [4];

  initial begin
    vec[0] = 2'b00; vec[1] = 2'b01; vec[2] = 2'b10; vec[3] = 2'b11;
    vexp[0] = 3'b010; vexp[1] = 3'b001;
    vexp[2] = 3'b100; vexp[3] = 3'b010;
    a1 = 0; b1 = 0; a4 = 0; b4 = 0;
    as1 = 0; bs1 = 0; a8 = 0; b8 = 0;

    #35;
    check("reset_state", {l1_1, l1_2, l1_3}, 3'b000);
    @(negedge clk); rst_n = 1'b1;
    edge_chk("rel_edge1", 3'b010);

    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k < 4) {a1, b1} = vec[k];
      @(posedge clk); #1;
      if (k >= 2) check($sformatf("seq%0d", k - 2),
                        {l1_1, l1_2, l1_3}, vexp[k-2]);
    end

    // Reset with the clock stopped
    @(negedge clk);
    clk_en = 1'b0;
    rst_n = 1'b0; a1 = 1'b1; b1 = 1'b0;
    #1;
    check("rst_noclk_a", {l1_1, l1_2, l1_3}, 3'b000);
    #50;
    check("rst_noclk_b", {l1_1, l1_2, l1_3}, 3'b000);
    rst_n = 1'b1;
    #3;
    clk_en = 1'b1;
    edge_chk("rst_e1", 3'b010);
    edge_chk("rst_e2", 3'b010);
    edge_chk("rst_e3", 3'b100);
    edge_chk("rst_e4", 3'b100);

    // Mid-run reset between edges
    @(negedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("mid_rst", {l1_1, l1_2, l1_3}, 3'b000);
    @(negedge clk); rst_n = 1'b1;
    edge_chk("mid_e1", 3'b010);
    edge_chk("mid_e2", 3'b010);
    edge_chk("mid_e3", 3'b100);

    // Width 4 and width 1 signed boundaries
    @(negedge clk);
    a4 = 4'b1000; b4 = 4'b0001; as1 = 1'b1; bs1 = 1'b0;
    repeat (3) @(posedge clk); #1;
    check("w4_uns", {l4u_1, l4u_2, l4u_3}, 3'b100);
    check("w4_sgn", {l4s_1, l4s_2, l4s_3}, 3'b001);
    check("w1_sgn", {l1s_1, l1s_2, l1s_3}, 3'b001);
    @(negedge clk);
    a4 = 4'b0111; b4 = 4'b1111; as1 = 1'b0; bs1 = 1'b1;
    repeat (3) @(posedge clk); #1;
    check("w4_uns2", {l4u_1, l4u_2, l4u_3}, 3'b001);
    check("w4_sgn2", {l4s_1, l4s_2, l4s_3}, 3'b100);
    check("w1_sgn2", {l1s_1, l1s_2, l1s_3}, 3'b100);
    @(negedge clk);
    a4 = 4'b1010; b4 = 4'b1010;
    repeat (3) @(posedge clk); #1;
    check("w4_eq", {l4s_1, l4s_2, l4s_3}, 3'b010);

    // Width 8 random sweep, each vector held 4 cycles
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      a8 = 8'($urandom);
      b8 = (i % 8 == 0) ? a8 : 8'($urandom);
      repeat (4) @(posedge clk); #1;
      check($sformatf("w8u_%0d", i), {l8u_1, l8u_2, l8u_3},
            gold(a8, b8, 1'b0));
      check($sformatf("w8s_%0d", i), {l8s_1, l8s_2, l8s_3},
            gold(a8, b8, 1'b1));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
